// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder, reused once per cycle by the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder step per cycle, LSB first, WIDTH cycles per operation.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int                IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WIDTH - 1);

    state_e             state_r;
    state_e             state_s;
    logic               accept_s;
    logic               last_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic               busy_r;
    logic               done_r;
    logic               cout_r;
    logic               ovf_r;
    logic               fa_s_s;
    logic               fa_c_s;

    fa_cell u_fa (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .cin  (carry_r),
        .s    (fa_s_s),
        .cout (fa_c_s)
    );

    // Next-state decode; DONE accepts a new start just like IDLE
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = (idx_r == IDX_LAST);
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s  = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_s  = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, operand shifters, carry flop, index counter and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
            if (accept_s) begin
                // Subtraction is a + ~b + 1; a borrow-in removes the +1
                a_r     <= a;
                b_r     <= sub ? ~b : b;
                carry_r <= cin ^ sub;
                idx_r   <= '0;
            end else if (state_r == RUN) begin
                a_r     <= {1'b0, a_r[WIDTH-1:1]};
                b_r     <= {1'b0, b_r[WIDTH-1:1]};
                sum_r   <= {fa_s_s, sum_r[WIDTH-1:1]};
                carry_r <= fa_c_s;
                if (last_s) begin
                    idx_r  <= '0;
                    cout_r <= fa_c_s;
                    ovf_r  <= carry_r ^ fa_c_s;
                end else begin
                    idx_r  <= idx_r + IDX_W'(1);
                end
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder at WIDTH=8, plus a short model-checked random sweep.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int vectors     = 0;
    int miscompares = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one operation, scramble inputs after the start edge, check latency, busy span and result
    task automatic do_op(input string tag, input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic c, input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1; sub = s; a = av; b = bv; cin = c;
        @(negedge clk);
        start = 1'b0; sub = ~s; a = ~av; b = 8'h5A; cin = ~c;
        n = 1;
        busy_cnt = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check_eq({tag, ".lat"}, 64'(n), 64'(W + 1));
        check_eq({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(W));
        check_eq({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        check_eq({tag, ".sum"}, 64'(sum), 64'(es));
        check_eq({tag, ".cout"}, 64'(cout), 64'(ec));
        check_eq({tag, ".ovf"}, 64'(ovf), 64'(eo));
        @(negedge clk);
        check_eq({tag, ".done_pulse"}, 64'(done), 64'd0);
        check_eq({tag, ".hold_sum"}, 64'(sum), 64'(es));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         rs;
        logic         rc;
        logic         eo;
        int           dcnt;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        check_eq("rst.busy", 64'(busy), 64'd0);
        check_eq("rst.done", 64'(done), 64'd0);
        check_eq("rst.sum", 64'(sum), 64'd0);
        check_eq("rst.cout", 64'(cout), 64'd0);
        check_eq("rst.ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("add7f01", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op("addff01c", 1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
        do_op("add0000", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        do_op("add8080", 1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        do_op("sub0507", 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
        do_op("sub0000b", 1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
        do_op("sub7fff", 1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op("sub8001", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

        // Asynchronous reset in the fourth RUN cycle, with cout/ovf still 1 from the last result
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 8'h11; b = 8'h22; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst.busy", 64'(busy), 64'd0);
        check_eq("arst.done", 64'(done), 64'd0);
        check_eq("arst.sum", 64'(sum), 64'd0);
        check_eq("arst.cout", 64'(cout), 64'd0);
        check_eq("arst.ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check_eq("arst.no_done", 64'(dcnt), 64'd0);
        do_op("add0304", 1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

        // start held for 20 cycles: re-accepted in each DONE cycle, operands garbage in between
        for (int c = 0; c < 29; c++) begin
            @(negedge clk);
            if (c > 0) begin
                check_eq($sformatf("b2b.done%0d", c), 64'(done), 64'((c % 9) == 0));
                if (done) check_eq($sformatf("b2b.sum%0d", c), 64'(sum), 64'h30);
            end
            start = (c < 20);
            sub   = 1'b0;
            cin   = 1'b0;
            if ((c % 9) == 0) begin
                a = 8'h10; b = 8'h20;
            end else begin
                a = 8'($urandom); b = 8'($urandom);
            end
        end
        start = 1'b0;

        // Random sweep against an arithmetic reference
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            bb = rs ? ~rb : rb;
            full = {1'b0, ra} + {1'b0, bb} + {8'd0, rc ^ rs};
            eo = (ra[W-1] == bb[W-1]) && (full[W-1] != ra[W-1]);
            do_op($sformatf("rnd%0d", i), rs, ra, rb, rc, full[W-1:0], full[W], eo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
